// File: rtl/spi_slave_core_pkg.sv
// Shared SPI link definitions: mode constants and the slave/master state encoding.
package spi_slave_core_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam bit CPOL_IDLE_LOW     = 1'b0;
  localparam bit CPOL_IDLE_HIGH    = 1'b1;
  localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
  localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_slave_core_if.sv
// Parallel word-side bus of the SPI slave: TX holding-register handshake and RX word output.
interface spi_slave_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_slave_core_sync_edge.sv
// Two-flop synchroniser with a third history flop for rise/fall detection on the synced value.
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INIT;
      s2 <= INIT;
      s3 <= INIT;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: oversampled pin synchronisers, MOSI deserialiser and a one-entry TX holding
// register serialised onto MISO.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  spi_slave_core_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_m, mosi_s;

  spi_sync_edge #(.INIT(CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.INIT(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_sh, tx_sh, hold_data, rx_data_r;
  logic             hold_full, tx_empty, rx_valid_r, underrun_r;

  logic             lead, trail, sample_edge, shift_edge;
  logic             last_sample, load;
  logic [WIDTH-1:0] rx_next, load_word;
  logic             load_empty;

  assign lead        = CPOL ? sclk_fall : sclk_rise;
  assign trail       = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  assign rx_next     = MSB_FIRST ? {rx_sh[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh[WIDTH-1:1]};
  assign last_sample = (state == ST_ACTIVE) && !cs_rise && sample_edge &&
                       (bit_cnt == CW'(WIDTH - 1));
  assign load        = ((state == ST_IDLE) && cs_fall) || last_sample;

  // A write landing in the load cycle bypasses the holding register.
  assign load_word   = hold_full ? hold_data : (bus.tx_valid ? bus.tx_data : '0);
  assign load_empty  = !hold_full && !bus.tx_valid;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      tx_empty   <= 1'b0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;

      if (load) begin
        hold_full <= 1'b0;
        tx_empty  <= load_empty;
        tx_sh     <= CPHA ? load_word : shifted(load_word);
        if (!CPHA) miso <= first_bit(load_word);
      end else if (bus.tx_valid && !hold_full) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            miso_oe <= 1'b1;
            bit_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state   <= ST_IDLE;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            // Underrun reported when an empty word actually starts, so the load that
            // follows a frame's final word stays silent if the master then deselects.
            if (bit_cnt == '0 && tx_empty) underrun_r <= 1'b1;
            if (last_sample) begin
              bit_cnt    <= '0;
              rx_data_r  <= rx_next;
              rx_valid_r <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (shift_edge && (CPHA || bit_cnt != '0)) begin
            miso  <= first_bit(tx_sh);
            tx_sh <= shifted(tx_sh);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_underrun = underrun_r;
endmodule
